// File: rtl/tinyriscv_soc_top.sv
// tinyriscv_soc_top: two single-cycle RV32I cores sharing one instruction ROM
// and one data RAM. chip_sel picks the core that owns the buses. The other
// core is held in reset. uart_debug_pin freezes the selected core.
//
// Data port handshake: a core drives addr/wdata/we with req=1 for a load or
// a store. rdata is valid combinationally in the same cycle. A store commits
// on the next rising clk edge. There is no ready/stall, so every request
// completes in the cycle it is issued.

// Instruction ROM with a fetch port and a writable data port.
// DEPTH must be a power of two, so slicing the index wraps modulo the depth.
module tinyriscv_rom #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic [AW-1:0] f_idx,
   output logic [31:0]   f_data,
   input  logic [AW-1:0] d_idx,
   output logic [31:0]   d_rdata,
   input  logic          we,
   input  logic [31:0]   wdata
);
   logic [31:0] _rom [0:DEPTH-1];

   assign f_data  = _rom[f_idx];
   assign d_rdata = _rom[d_idx];

   // Write the addressed word on the clock edge. A same-cycle read sees the old value.
   always_ff @(posedge clk) begin
      if (we) _rom[d_idx] <= wdata;
   end
endmodule

// Data RAM with a single combinational-read, clocked-write port.
module tinyriscv_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic [AW-1:0] d_idx,
   output logic [31:0]   d_rdata,
   input  logic          we,
   input  logic [31:0]   wdata
);
   logic [31:0] _ram [0:DEPTH-1];

   assign d_rdata = _ram[d_idx];

   // Write the addressed word on the clock edge. A same-cycle read sees the old value.
   always_ff @(posedge clk) begin
      if (we) _ram[d_idx] <= wdata;
   end
endmodule

// Register file. With INV=1 every word is stored complemented; x0 then holds all ones.
module rv_regs #(
   parameter bit INV = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_idx,
   input  logic [4:0]  rs2_idx,
   output logic [31:0] rs1_val,
   output logic [31:0] rs2_val,
   input  logic        rd_we,
   input  logic [4:0]  rd_idx,
   input  logic [31:0] rd_val
);
   localparam logic [31:0] FILL = {32{INV}};

   logic [31:0] regs [0:31];

   assign rs1_val = regs[rs1_idx] ^ FILL;
   assign rs2_val = regs[rs2_idx] ^ FILL;

   // Clear to architectural zero on reset. x0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= FILL;
      end else if (rd_we && rd_idx != 5'd0) begin
         regs[rd_idx] <= rd_val ^ FILL;
      end
   end
endmodule

// Single-cycle RV32I datapath. Sub-word stores merge into the word read back
// through the combinational data port in the same cycle.
module rv_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   output logic [31:0] pc_addr,
   input  logic [31:0] inst,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic        we,
   output logic        req,
   input  logic [31:0] rdata,
   output logic [4:0]  rs1_idx,
   output logic [4:0]  rs2_idx,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   output logic        rd_we,
   output logic [4:0]  rd_idx,
   output logic [31:0] rd_val
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic [31:0] pc, pc_next;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic        f7b5;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] alu_b, alu_y, sra_y, ld_sh, st_mask;
   logic [4:0]  sh_amt, byte_sh;
   logic        taken;
   logic        unused_bits;

   assign opcode  = inst[6:0];
   assign f3      = inst[14:12];
   assign f7b5    = inst[30];
   assign rs1_idx = inst[19:15];
   assign rs2_idx = inst[24:20];
   assign rd_idx  = inst[11:7];
   assign pc_addr = pc;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   assign addr    = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign byte_sh = {addr[1:0], 3'b000};
   assign ld_sh   = rdata >> byte_sh;
   assign alu_b   = (opcode == OP_OP) ? rs2_val : imm_i;
   assign sh_amt  = alu_b[4:0];
   assign sra_y   = $signed(rs1_val) >>> sh_amt;

   assign unused_bits = ^ld_sh[31:16];

   // ALU shared by register-register and register-immediate forms.
   always_comb begin
      alu_y = '0;
      case (f3)
         3'b000:  alu_y = (opcode == OP_OP && f7b5) ? rs1_val - alu_b : rs1_val + alu_b;
         3'b001:  alu_y = rs1_val << sh_amt;
         3'b010:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
         3'b011:  alu_y = {31'b0, rs1_val < alu_b};
         3'b100:  alu_y = rs1_val ^ alu_b;
         3'b101:  alu_y = f7b5 ? sra_y : rs1_val >> sh_amt;
         3'b110:  alu_y = rs1_val | alu_b;
         default: alu_y = rs1_val & alu_b;
      endcase
   end

   // Branch condition.
   always_comb begin
      taken = 1'b0;
      case (f3)
         3'b000:  taken = rs1_val == rs2_val;
         3'b001:  taken = rs1_val != rs2_val;
         3'b100:  taken = $signed(rs1_val) <  $signed(rs2_val);
         3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
         3'b110:  taken = rs1_val <  rs2_val;
         3'b111:  taken = rs1_val >= rs2_val;
         default: taken = 1'b0;
      endcase
   end

   // Store byte-lane mask for sb/sh/sw.
   always_comb begin
      case (f3[1:0])
         2'b00:   st_mask = 32'h0000_00FF << byte_sh;
         2'b01:   st_mask = 32'h0000_FFFF << byte_sh;
         default: st_mask = 32'hFFFF_FFFF;
      endcase
   end

   // Decode: next PC, memory request and register write-back.
   always_comb begin
      pc_next = pc + 32'd4;
      req     = 1'b0;
      we      = 1'b0;
      wdata   = (rdata & ~st_mask) | ((rs2_val << byte_sh) & st_mask);
      rd_we   = 1'b0;
      rd_val  = alu_y;
      case (opcode)
         OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
         OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
         OP_JAL:    begin rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = pc + imm_j; end
         OP_JALR:   begin rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = {addr[31:1], 1'b0}; end
         OP_BRANCH: if (taken) pc_next = pc + imm_b;
         OP_LOAD: begin
            req   = 1'b1;
            rd_we = 1'b1;
            case (f3)
               3'b000:  rd_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
               3'b001:  rd_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
               3'b100:  rd_val = {24'b0, ld_sh[7:0]};
               3'b101:  rd_val = {16'b0, ld_sh[15:0]};
               default: rd_val = rdata;
            endcase
         end
         OP_STORE:  begin req = 1'b1; we = 1'b1; end
         OP_IMM, OP_OP: rd_we = 1'b1;
         default:   ;  // fence / system execute as no-ops
      endcase
      if (hold) begin
         we    = 1'b0;
         rd_we = 1'b0;
      end
   end

   // Program counter. Frozen while held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        pc <= '0;
      else if (!hold) pc <= pc_next;
   end
endmodule

// Core with an architectural register file.
module tinyriscv (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        int_flag,
   output logic [31:0] pc_addr,
   input  logic [31:0] inst,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic        we,
   output logic        req,
   input  logic [31:0] rdata
);
   logic [4:0]  rs1_idx, rs2_idx, rd_idx;
   logic [31:0] rs1_val, rs2_val, rd_val;
   logic        rd_we;
   logic        unused_irq;

   assign unused_irq = int_flag;

   rv_core u_core (.*);
   rv_regs #(.INV(1'b0)) u_regs (.*);
endmodule

// Core whose register file stores the complement of every architectural value.
module tinyriscv_2023211063 (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        int_flag,
   output logic [31:0] pc_addr,
   input  logic [31:0] inst,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic        we,
   output logic        req,
   input  logic [31:0] rdata
);
   logic [4:0]  rs1_idx, rs2_idx, rd_idx;
   logic [31:0] rs1_val, rs2_val, rd_val;
   logic        rd_we;
   logic        unused_irq;

   assign unused_irq = int_flag;

   rv_core u_core (.*);
   rv_regs #(.INV(1'b1)) u_regs_2023211063 (.*);
endmodule

module tinyriscv_soc_top #(
   parameter int ROM_DEPTH = 4096,
   parameter int RAM_DEPTH = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic uart_debug_pin,
   input  logic chip_sel
);
   localparam int ROM_AW = $clog2(ROM_DEPTH);
   localparam int RAM_AW = $clog2(RAM_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_a, addr_a, wdata_a, pc_b, addr_b, wdata_b;
   logic        we_a, req_a, we_b, req_b;
   logic        rst_a, rst_b;
   logic [31:0] sel_pc, sel_addr, sel_wdata;
   logic        sel_we, sel_req;
   logic [31:0] inst_bus, rdata_bus, rom_fdata, rom_rdata, ram_rdata;
   logic        rom_hit, ram_hit, wr_ok;
   logic        unused_bits;

   // The unselected core sits in reset for as long as it is unselected.
   assign rst_a = rst | ~chip_sel;
   assign rst_b = rst | chip_sel;

   // Bus mux: only the selected core reaches the memories.
   always_comb begin
      sel_pc    = chip_sel ? pc_a    : pc_b;
      sel_addr  = chip_sel ? addr_a  : addr_b;
      sel_wdata = chip_sel ? wdata_a : wdata_b;
      sel_we    = chip_sel ? we_a    : we_b;
      sel_req   = chip_sel ? req_a   : req_b;
   end

   assign rom_hit   = sel_addr[31:28] == 4'h0;
   assign ram_hit   = sel_addr[31:28] == 4'h1;
   assign wr_ok     = sel_req & sel_we & ~rst & ~uart_debug_pin;
   assign inst_bus  = (sel_pc[31:28] == 4'h0) ? rom_fdata : NOP;
   assign rdata_bus = rom_hit ? rom_rdata : (ram_hit ? ram_rdata : 32'h0);

   assign unused_bits = ^{sel_pc, sel_addr};

   tinyriscv_rom #(.DEPTH(ROM_DEPTH), .AW(ROM_AW)) u_rom (
      .clk(clk), .f_idx(sel_pc[ROM_AW+1:2]), .f_data(rom_fdata),
      .d_idx(sel_addr[ROM_AW+1:2]), .d_rdata(rom_rdata),
      .we(wr_ok & rom_hit), .wdata(sel_wdata)
   );

   tinyriscv_ram #(.DEPTH(RAM_DEPTH), .AW(RAM_AW)) u_ram (
      .clk(clk), .d_idx(sel_addr[RAM_AW+1:2]), .d_rdata(ram_rdata),
      .we(wr_ok & ram_hit), .wdata(sel_wdata)
   );

   tinyriscv u_tinyriscv (
      .clk(clk), .rst(rst_a), .hold(uart_debug_pin), .int_flag(1'b0),
      .pc_addr(pc_a), .inst(inst_bus), .addr(addr_a), .wdata(wdata_a),
      .we(we_a), .req(req_a), .rdata(rdata_bus)
   );

   tinyriscv_2023211063 u_tinyriscv_2023211063 (
      .clk(clk), .rst(rst_b), .hold(uart_debug_pin), .int_flag(1'b0),
      .pc_addr(pc_b), .inst(inst_bus), .addr(addr_b), .wdata(wdata_b),
      .we(we_b), .req(req_b), .rdata(rdata_bus)
   );
endmodule

// File: tb/tb_tinyriscv_soc_top.sv
// Directed bench for tinyriscv_soc_top: a hand-assembled program exercising
// word/byte memory access, unmapped regions, a loop, a jump, debug hold,
// core selection and mid-run reset.
module tb_tinyriscv_soc_top;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_debug_pin = 1'b0;
   logic chip_sel = 1'b1;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q [$];
   int          idx_q [$];
   logic [31:0] prog  [0:24];

   localparam int OP_LUI = 7'b0110111;
   localparam int OP_IMM = 7'b0010011;
   localparam int OP_LD  = 7'b0000011;
   localparam int PC_END = 32'h60;

   // clock / reset block: 50 MHz
   always #10 clk = ~clk;

   tinyriscv_soc_top #(.ROM_DEPTH(4096), .RAM_DEPTH(4096)) dut (
      .clk(clk), .rst(rst), .uart_debug_pin(uart_debug_pin), .chip_sel(chip_sel)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int op, input int rd, input int f3, input int rs1, input int imm);
      enc_i = {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
      enc_s = {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
      enc_b = {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(input int op, input int rd, input int imm);
      enc_u = {imm[19:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
      enc_r = {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_j(input int rd, input int imm);
      enc_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
   endfunction

   function automatic logic [31:0] cur_pc();
      cur_pc = chip_sel ? dut.u_tinyriscv.u_core.pc : dut.u_tinyriscv_2023211063.u_core.pc;
   endfunction

   // Architectural value of register i of the currently selected core.
   function automatic logic [31:0] arch_reg(input int i);
      arch_reg = chip_sel ? dut.u_tinyriscv.u_regs.regs[i]
                          : ~dut.u_tinyriscv_2023211063.u_regs_2023211063.regs[i];
   endfunction

   // driver: assemble the program and load it into the ROM
   task automatic load_program();
      prog[0]  = enc_u(OP_LUI, 1, 32'h10000);
      prog[1]  = enc_u(OP_LUI, 2, 32'hA5A5A);
      prog[2]  = enc_i(OP_IMM, 2, 0, 2, 32'h5A5);
      prog[3]  = enc_s(2, 1, 2, 16);          // 0x0C sw x2,16(x1)
      prog[4]  = enc_i(OP_LD, 5, 2, 1, 16);   // lw x5
      prog[5]  = enc_i(OP_IMM, 6, 0, 0, 7);
      prog[6]  = enc_u(OP_LUI, 3, 32'h30000);
      prog[7]  = enc_i(OP_LD, 6, 2, 3, 0);    // lw from unmapped
      prog[8]  = enc_s(2, 3, 2, 0);           // 0x20 sw to unmapped
      prog[9]  = enc_i(OP_IMM, 7, 0, 0, 32'h7F);
      prog[10] = enc_s(0, 1, 7, 17);          // 0x28 sb x7,17(x1)
      prog[11] = enc_i(OP_LD, 8, 2, 1, 16);   // lw
      prog[12] = enc_i(OP_LD, 9, 0, 1, 16);   // lb
      prog[13] = enc_i(OP_LD, 12, 4, 1, 16);  // lbu
      prog[14] = enc_i(OP_IMM, 10, 0, 0, 5);
      prog[15] = enc_i(OP_IMM, 11, 0, 0, 0);
      prog[16] = enc_i(OP_IMM, 10, 0, 10, -1); // 0x40 loop
      prog[17] = enc_i(OP_IMM, 11, 0, 11, 1);
      prog[18] = enc_b(1, 10, 0, -8);          // bne x10,x0,loop
      prog[19] = enc_r(7'b0100000, 0, 13, 5, 8);
      prog[20] = enc_j(14, 8);                 // 0x50 jal x14,+8
      prog[21] = enc_i(OP_IMM, 11, 0, 11, 100); // skipped
      prog[22] = enc_i(OP_IMM, 27, 0, 0, 1);
      prog[23] = enc_i(OP_IMM, 26, 0, 0, 1);
      prog[24] = enc_j(0, 0);                  // 0x60 spin
      for (int i = 0; i < 25; i++) dut.u_rom._rom[i] = prog[i];
   endtask

   task automatic wait_pc(input logic [31:0] target, input int budget, input string tag);
      int n = 0;
      while (cur_pc() != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, cur_pc(), target);
   endtask

   task automatic reset_pulse(input logic sel);
      @(negedge clk);
      rst = 1'b1;
      chip_sel = sel;
      dut.u_ram._ram[4] = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic expect_reg(input int i, input logic [31:0] v);
      idx_q.push_back(i);
      exp_q.push_back(v);
   endtask

   // scoreboard: expected final registers of the program
   task automatic score_program(input string tag);
      expect_reg(1, 32'h1000_0000);  expect_reg(2, 32'hA5A5_A5A5);
      expect_reg(3, 32'h3000_0000);  expect_reg(5, 32'hA5A5_A5A5);
      expect_reg(6, 32'h0);          expect_reg(7, 32'h7F);
      expect_reg(8, 32'hA5A5_7FA5);  expect_reg(9, 32'hFFFF_FFA5);
      expect_reg(10, 32'h0);         expect_reg(11, 32'd5);
      expect_reg(12, 32'hA5);        expect_reg(13, 32'h2600);
      expect_reg(14, 32'h54);        expect_reg(26, 32'd1);
      expect_reg(27, 32'd1);         expect_reg(0, 32'h0);
      while (exp_q.size() > 0) begin
         int i;
         logic [31:0] e;
         i = idx_q.pop_front();
         e = exp_q.pop_front();
         check($sformatf("%s_x%0d", tag, i), arch_reg(i), e);
      end
      check({tag, "_ram4"}, dut.u_ram._ram[4], 32'hA5A5_7FA5);
      check({tag, "_ram0"}, dut.u_ram._ram[0], 32'h1234_5678);
      check({tag, "_rom0"}, dut.u_rom._rom[0], prog[0]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      load_program();
      dut.u_ram._ram[0] = 32'h1234_5678;
      dut.u_ram._ram[4] = 32'h0;

      // reset state
      @(negedge clk);
      check("rst_pc_a", dut.u_tinyriscv.u_core.pc, 32'h0);
      check("rst_pc_b", dut.u_tinyriscv_2023211063.u_core.pc, 32'h0);
      check("rst_x0_inv", dut.u_tinyriscv_2023211063.u_regs_2023211063.regs[0], 32'hFFFF_FFFF);
      check("rst_ram0", dut.u_ram._ram[0], 32'h1234_5678);
      @(negedge clk);
      rst = 1'b0;

      // run 1: core A, store timing
      wait_pc(32'h0C, 20, "r1_reach_sw");
      check("r1_ram4_before", dut.u_ram._ram[4], 32'h0);
      @(negedge clk);
      check("r1_ram4_after", dut.u_ram._ram[4], 32'hA5A5_A5A5);
      wait_pc(PC_END, 200, "r1_done");
      score_program("r1");

      // run 2: debug hold on the store
      reset_pulse(1'b1);
      wait_pc(32'h0C, 20, "r2_reach_sw");
      uart_debug_pin = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("r2_hold_pc%0d", c), cur_pc(), 32'h0C);
         check($sformatf("r2_hold_ram%0d", c), dut.u_ram._ram[4], 32'h0);
         check($sformatf("r2_hold_x2_%0d", c), arch_reg(2), 32'hA5A5_A5A5);
      end
      check("r2_hold_x1", arch_reg(1), 32'h1000_0000);
      uart_debug_pin = 1'b0;
      @(negedge clk);
      check("r2_release_ram4", dut.u_ram._ram[4], 32'hA5A5_A5A5);
      wait_pc(PC_END, 200, "r2_done");
      score_program("r2");

      // run 3: core B, core A held in reset
      reset_pulse(1'b0);
      repeat (5) @(negedge clk);
      check("r3_pc_a_held", dut.u_tinyriscv.u_core.pc, 32'h0);
      wait_pc(PC_END, 200, "r3_done");
      check("r3_x0_raw", dut.u_tinyriscv_2023211063.u_regs_2023211063.regs[0], 32'hFFFF_FFFF);
      check("r3_x5_raw", dut.u_tinyriscv_2023211063.u_regs_2023211063.regs[5], 32'h5A5A_5A5A);
      score_program("r3");

      // run 4: reset asserted while the sb is pending
      reset_pulse(1'b0);
      wait_pc(32'h28, 40, "r4_reach_sb");
      rst = 1'b1;
      #1;
      check("r4_pc_async", cur_pc(), 32'h0);
      @(negedge clk);
      check("r4_ram4_kept", dut.u_ram._ram[4], 32'hA5A5_A5A5);
      rst = 1'b0;
      wait_pc(PC_END, 200, "r4_done");
      score_program("r4");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tinyriscv_soc_top.md
TINYRISCV_SOC_TOP -- requirements
Module: tinyriscv_soc_top

Interface
REQ-001 The block SHALL have parameter ROM_DEPTH, default 4096, meaning the number of 32-bit instruction ROM words.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 4096, meaning the number of 32-bit data RAM words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock (50 MHz nominal), and every sequential element SHALL use its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port uart_debug_pin, input, 1 bit: debug-hold request; 1 SHALL halt both cores.
REQ-006 The block SHALL have port chip_sel, input, 1 bit: core select; 1 SHALL select u_tinyriscv and 0 SHALL select u_tinyriscv_2023211063.
REQ-007 The block SHALL have no output ports; program results SHALL be observable only through hierarchical register access.

Function
REQ-008 The block SHALL instantiate ROM instance u_rom holding array _rom[0:ROM_DEPTH-1] of 32-bit words, loadable by $readmemh with one word per line.
REQ-009 The block SHALL instantiate the existing core u_tinyriscv, whose register file u_regs.regs[0:31] SHALL hold architectural values.
REQ-010 The block SHALL instantiate the existing core u_tinyriscv_2023211063, whose register file u_regs_2023211063.regs[0:31] SHALL hold the bitwise complement of architectural values (x0 stored as 0xFFFFFFFF).
REQ-011 Each core SHALL expose an instruction port (pc_addr out, inst in) and a word-wide data port (addr, wdata, we, req out; rdata in); sub-word loads and stores SHALL be resolved inside the core.
REQ-012 The unselected core SHALL be held in reset, and only the selected core's ports SHALL drive ROM and RAM.
REQ-013 A chip_sel change SHALL switch the bus mux combinationally and SHALL put the newly unselected core into reset immediately.
REQ-014 Address map: addr[31:28]=0x0 SHALL select ROM at word index addr[2+log2(ROM_DEPTH)-1:2], and addr[31:28]=0x1 SHALL select RAM at the equivalent word index.
REQ-015 Unmapped reads SHALL return 0x00000000, and unmapped writes SHALL be ignored.
REQ-016 Instruction fetch SHALL read ROM combinationally through a dedicated read port, and a fetch from a non-ROM region SHALL return 0x00000013 (NOP).
REQ-017 Data reads from ROM or RAM SHALL be combinational (0-cycle latency).
REQ-018 A data write with req=1 and we=1 SHALL update the addressed ROM or RAM word at the next rising clk edge.
REQ-019 A data read of a word in the same cycle as a write to that word SHALL return the old value.
REQ-020 Fetch and data accesses SHALL never conflict; the cores' hold/stall input SHALL be driven only by uart_debug_pin.
REQ-021 While uart_debug_pin=1, the selected core SHALL hold its PC and register file, and no memory writes SHALL occur.
REQ-022 Core interrupt inputs SHALL be tied to 0.
REQ-023 Out-of-range word indices within a region SHALL wrap modulo the region depth.

Reset
REQ-024 While rst=1, both cores SHALL be in reset, with PC=0x00000000 and no memory writes.
REQ-025 After rst falls, the selected core SHALL fetch from 0x00000000 on the first rising edge.
REQ-026 ROM and RAM contents SHALL NOT be altered by reset.
REQ-027 A reset asserted mid-program SHALL abort the in-flight instruction with no partial write.

Verification
REQ-028 Scenario: chip_sel=1, ROM preloaded with an rv32i ISA test, rst high 40 ns then low -> u_regs.regs[26]=1 within 1 ms; regs[27]=1 on pass; regs[3] holds the failing test number otherwise.
REQ-029 Scenario: same program with chip_sel=0 -> ~u_regs_2023211063.regs[26]=1 and ~regs[27]=1 within 1 ms.
REQ-030 Scenario: program "sw 0xA5A5A5A5 to 0x10000010; lw back to x5" -> x5=0xA5A5A5A5, and RAM word 4 changes on the store's clk edge.
REQ-031 Scenario: lw from 0x30000000 -> 0x00000000; sw to 0x30000000 -> no ROM or RAM change.
REQ-032 Scenario: uart_debug_pin=1 for 10 cycles mid-program -> PC and all registers unchanged during hold; program completes correctly after release.
REQ-033 Scenario: rst pulsed mid-run -> PC returns to 0; a stored value written before the pulse is retained in RAM.
